// File: rtl/preamble_tx.sv
// preamble_tx
// Burst source for a DUC. On a start pulse it emits a preamble of REPS
// identical repetitions of a PERIOD-sample QPSK-like pattern (I/Q = +/-AMP
// chosen by a 15-bit LFSR), then passes payload words through until the word
// flagged last. One sample is produced per duc_in_strobe.
//
// Ports:
//   clk            - clock
//   rst            - synchronous active-high reset
//   start          - one-cycle pulse launching a burst (honoured only in IDLE)
//   duc_in_strobe  - DUC sample request, one sample per high cycle
//   duc_in_sample  - registered {I[31:16], Q[15:0]} sample for the DUC
//   payload_sample - upstream payload word
//   payload_valid  - payload word available
//   payload_last   - marks final payload word of the burst
//   payload_ready  - payload word accepted this cycle (combinational)
//   tx_active      - high while a burst is in progress
//   preamble_done  - one-cycle pulse after the last preamble sample
//   underrun       - sticky flag: a strobe found no payload word
module preamble_tx #(
  parameter int          PERIOD = 32,
  parameter int          REPS   = 10,
  parameter logic [15:0] AMP    = 16'h2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        duc_in_strobe,
  output logic [31:0] duc_in_sample,
  input  logic [31:0] payload_sample,
  input  logic        payload_valid,
  input  logic        payload_last,
  output logic        payload_ready,
  output logic        tx_active,
  output logic        preamble_done,
  output logic        underrun
);

  localparam int                 CNT_W       = $clog2(PERIOD);
  localparam logic [CNT_W-1:0]   LAST_SAMPLE = CNT_W'(PERIOD - 1);
  localparam logic [7:0]         LAST_REP    = 8'(REPS - 1);
  localparam logic [15:0]        NEG_AMP     = (~AMP) + 16'd1;
  localparam logic [14:0]        LFSR_SEED   = 15'h7FFF;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   sample_cnt_reg, sample_cnt_next;
  logic [7:0]         rep_cnt_reg, rep_cnt_next;
  logic [14:0]        lfsr_reg, lfsr_next;
  logic [31:0]        sample_reg, sample_next;
  logic               tx_active_reg, tx_active_next;
  logic               preamble_done_reg, preamble_done_next;
  logic               underrun_reg, underrun_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      sample_cnt_reg    <= '0;
      rep_cnt_reg       <= '0;
      lfsr_reg          <= LFSR_SEED;
      sample_reg        <= '0;
      tx_active_reg     <= 1'b0;
      preamble_done_reg <= 1'b0;
      underrun_reg      <= 1'b0;
    end else begin
      state_reg         <= state_next;
      sample_cnt_reg    <= sample_cnt_next;
      rep_cnt_reg       <= rep_cnt_next;
      lfsr_reg          <= lfsr_next;
      sample_reg        <= sample_next;
      tx_active_reg     <= tx_active_next;
      preamble_done_reg <= preamble_done_next;
      underrun_reg      <= underrun_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    sample_cnt_next    = sample_cnt_reg;
    rep_cnt_next       = rep_cnt_reg;
    lfsr_next          = lfsr_reg;
    sample_next        = sample_reg;
    underrun_next      = underrun_reg;
    preamble_done_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // A strobe coinciding with start still emits silence; the first
        // preamble sample goes out on the following strobe.
        if (duc_in_strobe) begin
          sample_next = 32'h0;
        end
        if (start) begin
          state_next      = PREAMBLE;
          underrun_next   = 1'b0;
          sample_cnt_next = '0;
          rep_cnt_next    = '0;
          lfsr_next       = LFSR_SEED;
        end
      end

      PREAMBLE: begin
        if (duc_in_strobe) begin
          sample_next = {lfsr_reg[0] ? NEG_AMP : AMP,
                         lfsr_reg[1] ? NEG_AMP : AMP};
          if (sample_cnt_reg == LAST_SAMPLE) begin
            // Reseeding at each wrap makes every repetition bit-identical.
            sample_cnt_next = '0;
            rep_cnt_next    = rep_cnt_reg + 8'd1;
            lfsr_next       = LFSR_SEED;
            if (rep_cnt_reg == LAST_REP) begin
              state_next         = PAYLOAD;
              rep_cnt_next       = '0;
              preamble_done_next = 1'b1;
            end
          end else begin
            sample_cnt_next = sample_cnt_reg + 1'b1;
            lfsr_next       = {lfsr_reg[13:0], lfsr_reg[14] ^ lfsr_reg[13]};
          end
        end
      end

      PAYLOAD: begin
        if (duc_in_strobe) begin
          if (payload_valid) begin
            sample_next = payload_sample;
            if (payload_last) begin
              state_next = IDLE;
            end
          end else begin
            sample_next   = 32'h0;
            underrun_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Registered copy of (state != IDLE), aligned with the state register.
    tx_active_next = (state_next != IDLE);
  end

  assign payload_ready = (state_reg == PAYLOAD) & duc_in_strobe & ~rst;
  assign duc_in_sample = sample_reg;
  assign tx_active     = tx_active_reg;
  assign preamble_done = preamble_done_reg;
  assign underrun      = underrun_reg;

endmodule

// File: tb/tb_preamble_tx.sv
// Directed self-checking bench for preamble_tx (PERIOD=32, REPS=4, AMP=16'h2000).
module tb_preamble_tx;

  localparam int PERIOD = 32;
  localparam int REPS   = 4;
  localparam int TOTAL  = PERIOD * REPS;

  logic        clk;
  logic        rst;
  logic        start;
  logic        duc_in_strobe;
  logic [31:0] duc_in_sample;
  logic [31:0] payload_sample;
  logic        payload_valid;
  logic        payload_last;
  logic        payload_ready;
  logic        tx_active;
  logic        preamble_done;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  logic [31:0] captured [TOTAL];

  preamble_tx #(.PERIOD(PERIOD), .REPS(REPS), .AMP(16'h2000)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .duc_in_strobe  (duc_in_strobe),
    .duc_in_sample  (duc_in_sample),
    .payload_sample (payload_sample),
    .payload_valid  (payload_valid),
    .payload_last   (payload_last),
    .payload_ready  (payload_ready),
    .tx_active      (tx_active),
    .preamble_done  (preamble_done),
    .underrun       (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference preamble sample n, computed from the LFSR recurrence.
  function automatic logic [31:0] exp_sample(input int n);
    logic [14:0] l;
    l = 15'h7FFF;
    for (int i = 0; i < (n % PERIOD); i++) l = {l[13:0], l[14] ^ l[13]};
    return {l[0] ? 16'hE000 : 16'h2000, l[1] ? 16'hE000 : 16'h2000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues count preamble strobes separated by gap idle cycles. start is
  // pulsed together with strobe number start_at (negative: never).
  task automatic run_preamble(input int count, input int gap, input int start_at);
    int pulses;
    logic [31:0] exp;
    pulses = 0;
    for (int k = 0; k < count; k++) begin
      start = (k == start_at);
      duc_in_strobe = 1'b1;
      tick();
      start = 1'b0;
      duc_in_strobe = 1'b0;
      exp = exp_sample(k);
      captured[k] = duc_in_sample;
      checks++;
      if (duc_in_sample !== exp) begin
        errors++;
        $display("FAIL preamble_sample[%0d] got %h expected %h", k, duc_in_sample, exp);
      end
      checks++;
      if (preamble_done !== (k == TOTAL - 1)) begin
        errors++;
        $display("FAIL preamble_done[%0d] got %b expected %b", k, preamble_done, (k == TOTAL - 1));
      end
      checks++;
      if (tx_active !== 1'b1) begin
        errors++;
        $display("FAIL tx_active_preamble[%0d] got %b expected 1", k, tx_active);
      end
      if (preamble_done === 1'b1) pulses++;
      for (int g = 0; g < gap; g++) begin
        tick();
        checks++;
        if (duc_in_sample !== exp || preamble_done !== 1'b0) begin
          errors++;
          $display("FAIL hold_between_strobes[%0d] got %h/%b expected %h/0", k, duc_in_sample, preamble_done, exp);
        end
      end
    end
    if (count == TOTAL) begin
      tick();
      checks++;
      if (preamble_done !== 1'b0) begin
        errors++;
        $display("FAIL preamble_done_width got %b expected 0", preamble_done);
      end
      checks++;
      if (pulses != 1) begin
        errors++;
        $display("FAIL preamble_done_count got %0d expected 1", pulses);
      end
    end
    $display("preamble run: %0d strobes gap %0d start_at %0d", count, gap, start_at);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; duc_in_strobe = 1'b1;
    #1;
    checks++;
    if (payload_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_payload_ready got %b expected 0", payload_ready);
    end
    tick();
    checks++;
    if ({duc_in_sample, tx_active, preamble_done, underrun, payload_ready} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h %b%b%b%b expected all 0",
               duc_in_sample, tx_active, preamble_done, underrun, payload_ready);
    end
    rst = 1'b0; start = 1'b0; duc_in_strobe = 1'b0;
    tick();
    checks++;
    if (tx_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got tx_active %b expected 0", tx_active);
    end
    $display("reset: sample %h tx_active %b", duc_in_sample, tx_active);
  endtask

  task automatic test_preamble();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (tx_active !== 1'b1 || duc_in_sample !== 32'h0) begin
      errors++;
      $display("FAIL start_launch got %b/%h expected 1/00000000", tx_active, duc_in_sample);
    end
    run_preamble(TOTAL, 0, -1);
    // Hand-derived: seed 7FFF -> 7FFE -> 7FFC.
    checks++;
    if (captured[0] !== 32'hE000E000) begin
      errors++;
      $display("FAIL first_sample got %h expected E000E000", captured[0]);
    end
    checks++;
    if (captured[1] !== 32'h2000E000) begin
      errors++;
      $display("FAIL second_sample got %h expected 2000E000", captured[1]);
    end
    checks++;
    if (captured[2] !== 32'h20002000) begin
      errors++;
      $display("FAIL third_sample got %h expected 20002000", captured[2]);
    end
    for (int n = 0; n < TOTAL - PERIOD; n++) begin
      checks++;
      if (captured[n] !== captured[n + PERIOD]) begin
        errors++;
        $display("FAIL periodicity[%0d] got %h expected %h", n, captured[n + PERIOD], captured[n]);
      end
    end
  endtask

  task automatic test_payload();
    logic [31:0] words [3];
    words[0] = 32'h1024BEEF; words[1] = 32'h1025BEF0; words[2] = 32'h1026BEF1;
    for (int w = 0; w < 3; w++) begin
      payload_sample = words[w];
      payload_valid = 1'b1;
      payload_last = (w == 2);
      duc_in_strobe = 1'b1;
      #1;
      checks++;
      if (payload_ready !== 1'b1) begin
        errors++;
        $display("FAIL payload_ready[%0d] got %b expected 1", w, payload_ready);
      end
      tick();
      duc_in_strobe = 1'b0;
      payload_valid = 1'b0;
      payload_last = 1'b0;
      checks++;
      if (duc_in_sample !== words[w] || tx_active !== (w != 2)) begin
        errors++;
        $display("FAIL payload_word[%0d] got %h/%b expected %h/%b", w, duc_in_sample, tx_active, words[w], (w != 2));
      end
      $display("payload word %0d: sample %h tx_active %b", w, duc_in_sample, tx_active);
    end
  endtask

  task automatic test_start_strobe_every4();
    // In IDLE with last payload word still on the output.
    start = 1'b1; duc_in_strobe = 1'b1;
    tick();
    start = 1'b0; duc_in_strobe = 1'b0;
    checks++;
    if (duc_in_sample !== 32'h0 || tx_active !== 1'b1) begin
      errors++;
      $display("FAIL start_with_strobe got %h/%b expected 00000000/1", duc_in_sample, tx_active);
    end
    run_preamble(TOTAL, 3, -1);
  endtask

  task automatic test_underrun();
    duc_in_strobe = 1'b0;
    #1;
    checks++;
    if (payload_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_no_strobe got %b expected 0", payload_ready);
    end
    payload_valid = 1'b0; duc_in_strobe = 1'b1;
    tick();
    duc_in_strobe = 1'b0;
    checks++;
    if (duc_in_sample !== 32'h0 || underrun !== 1'b1 || tx_active !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set got %h/%b/%b expected 00000000/1/1", duc_in_sample, underrun, tx_active);
    end
    tick();
    payload_sample = 32'hCAFE0001; payload_valid = 1'b1; payload_last = 1'b1; duc_in_strobe = 1'b1;
    tick();
    payload_valid = 1'b0; payload_last = 1'b0; duc_in_strobe = 1'b0;
    checks++;
    if (duc_in_sample !== 32'hCAFE0001 || underrun !== 1'b1 || tx_active !== 1'b0) begin
      errors++;
      $display("FAIL underrun_sticky got %h/%b/%b expected CAFE0001/1/0", duc_in_sample, underrun, tx_active);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (underrun !== 1'b0 || tx_active !== 1'b1) begin
      errors++;
      $display("FAIL underrun_clear got %b/%b expected 0/1", underrun, tx_active);
    end
    $display("underrun: flag %b after restart", underrun);
  endtask

  task automatic test_reset_mid_burst();
    run_preamble(40, 0, -1);
    rst = 1'b1; start = 1'b1; duc_in_strobe = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; duc_in_strobe = 1'b0;
    checks++;
    if ({duc_in_sample, tx_active, preamble_done, underrun} !== 35'h0) begin
      errors++;
      $display("FAIL reset_mid_burst got %h %b%b%b expected all 0", duc_in_sample, tx_active, preamble_done, underrun);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    // Start pulsed alongside strobe 60 must not disturb the sequence.
    run_preamble(TOTAL, 0, 60);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; duc_in_strobe = 1'b0;
    payload_sample = 32'h0; payload_valid = 1'b0; payload_last = 1'b0;
    tick();
    tick();
    test_reset();
    test_preamble();
    test_payload();
    test_start_strobe_every4();
    test_underrun();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
